// File: rtl/pi1_membridge.sv
// rtl/pi1_membridge.sv - PerInt slave to req/ack word-memory bridge with serialised swap
// Optional PI1_MEMBRIDGE_TIMEOUT_EN aborts a request left unacknowledged for TIMEOUT cycles.
module pi1_membridge #(
    parameter int ARCHBITSZ = 16,
    parameter int TIMEOUT   = 255,
    parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDRBITSZ-1:0]   mem_addr_o,
    output logic [ARCHBITSZ-1:0]   mem_data_o,
    output logic [ARCHBITSZ/8-1:0] mem_sel_o,
    input  logic [ARCHBITSZ-1:0]   mem_data_i,
    input  logic                   mem_ack_i,
    output logic                   err_o
);

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RWRD,
        RWWR
    } state_t;

    state_t state;
    state_t next_state;
    logic   timeout_hit;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                case (pi1_op_i)
                    PIRDOP:  next_state = RD;
                    PIWROP:  next_state = WR;
                    PIRWOP:  next_state = RWRD;
                    default: next_state = IDLE;
                endcase
            end
            RD, WR, RWWR: begin
                if (mem_ack_i || timeout_hit) begin
                    next_state = IDLE;
                end
            end
            RWRD: begin
                // A timed-out read phase drops the write phase entirely.
                if (mem_ack_i) begin
                    next_state = RWWR;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign pi1_rdy_o = (state == IDLE);
    assign mem_req_o = (state != IDLE);
    assign mem_we_o  = (state == WR) || (state == RWWR);

    // Both swap phases reuse the request fields captured at accept time.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && pi1_op_i != PINOOP) begin
            mem_addr_o <= pi1_addr_i;
            mem_data_o <= pi1_data_i;
            mem_sel_o  <= pi1_sel_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pi1_data_o <= '0;
        end else if ((state == RD || state == RWRD) && mem_ack_i) begin
            pi1_data_o <= mem_data_i;
        end else if (timeout_hit) begin
            pi1_data_o <= '1;
        end
    end

`ifdef PI1_MEMBRIDGE_TIMEOUT_EN
    localparam int            CNTW   = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] TO_MAX = CNTW'(TIMEOUT);

    logic [CNTW-1:0] to_cnt;

    // Clearing on ack restarts the count for the write phase of a swap.
    always_ff @(posedge clk_i) begin
        if (rst_i || state == IDLE || mem_ack_i) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state != IDLE) && !mem_ack_i && (to_cnt == TO_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_pi1_membridge.sv
// tb/tb_pi1_membridge.sv - scoreboard bench for pi1_membridge against a wait-state memory model
module tb_pi1_membridge;

    localparam logic [1:0] NOOP = 2'b00;
    localparam logic [1:0] WROP = 2'b01;
    localparam logic [1:0] RDOP = 2'b10;
    localparam logic [1:0] RWOP = 2'b11;
    localparam int TO_CYC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pi1_op = NOOP;
    logic [14:0] pi1_addr = '0;
    logic [15:0] pi1_wdata = '0;
    logic [15:0] pi1_rdata;
    logic [1:0]  pi1_sel = '0;
    logic        pi1_rdy;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_sel;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = '0;

    int wait_cfg = 0;
    int req_cycles = 0;
    bit ack_en = 1'b1;
    bit ack_force = 1'b0;
    bit prev_rdy = 1'b1;

    pi1_membridge #(.ARCHBITSZ(16), .TIMEOUT(TO_CYC)) dut (
        .clk_i(clk), .rst_i(rst),
        .pi1_op_i(pi1_op), .pi1_addr_i(pi1_addr), .pi1_data_i(pi1_wdata),
        .pi1_data_o(pi1_rdata), .pi1_sel_i(pi1_sel), .pi1_rdy_o(pi1_rdy),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_sel_o(mem_sel), .mem_data_i(mem_rdata),
        .mem_ack_i(mem_ack), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] s);
        merge = old;
        if (s[0]) merge[7:0]  = nw[7:0];
        if (s[1]) merge[15:8] = nw[15:8];
    endfunction

    // Memory model: ack after wait_cfg stalled request cycles, per phase.
    assign mem_ack   = ack_force | (ack_en & mem_req & (req_cycles == wait_cfg));
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) req_cycles <= 0;
        else req_cycles <= req_cycles + 1;
        if (!rst && mem_req && mem_ack && mem_we)
            mem[mem_addr[7:0]] <= merge(mem[mem_addr[7:0]], mem_wdata, mem_sel);
    end

    // Result monitor: each return of pi1_rdy_o retires one scoreboard entry.
    always @(posedge clk) begin
        logic [15:0] e;
        #2;
        if (pi1_rdy === 1'b1 && !prev_rdy) begin
            check("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_result", pi1_rdata, e);
            end
        end
        prev_rdy = (pi1_rdy === 1'b1);
    end

    task automatic issue(input logic [1:0] op, input logic [14:0] a, input logic [15:0] d,
                         input logic [1:0] s, input int waits, input bit to);
        int edges = 0;
        int reqc = 0;
        int errc = 0;
        int exp_lat;
        bit first = 1'b1;
        logic last_we = 1'b0;
        logic [15:0] e;
        wait_cfg = waits;
        ack_en = !to;
        if (to) begin
            e = '1;
            exp_lat = TO_CYC + 2;
        end else begin
            e = (op == WROP) ? last_exp : ref_mem[a[7:0]];
            if (op != RDOP) ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, s);
            exp_lat = (op == RWOP) ? 3 + 2 * waits : 2 + waits;
        end
        last_exp = e;
        exp_q.push_back(e);
        pi1_op = op; pi1_addr = a; pi1_wdata = d; pi1_sel = s;
        @(posedge clk); #1;
        // Scramble the inputs: the bridge must use its latched copy.
        pi1_op = NOOP; pi1_addr = ~a; pi1_wdata = ~d; pi1_sel = ~s;
        while (pi1_rdy !== 1'b1 && edges < 100) begin
            if (mem_req === 1'b1) begin
                reqc++;
                if (first) begin
                    check("first_we", mem_we, op == WROP);
                    check("mem_addr", mem_addr, a);
                    check("mem_sel", mem_sel, s);
                    if (op != RDOP) check("mem_data", mem_wdata, d);
                    first = 1'b0;
                end
                last_we = mem_we;
            end
            if (err === 1'b1) errc++;
            @(posedge clk); #1;
            edges++;
        end
        if (err === 1'b1) errc++;
        check("latency", edges + 1, exp_lat);
        check("req_cycles", reqc, exp_lat - 1);
        check("err_pulses", errc, to);
        if (op == RWOP && !to) check("swap_wr_phase", last_we, 1);
        if (to) begin
            @(posedge clk); #1;
            check("err_cleared", err, 0);
        end
        ack_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", pi1_rdy, 1);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_data", pi1_rdata, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("noop_idle", {pi1_rdy, mem_req}, 2'b10);

        issue(WROP, 15'h12, 16'hBEEF, 2'b11, 0, 1'b0);
        issue(RDOP, 15'h12, 16'h0000, 2'b11, 3, 1'b0);
        issue(RWOP, 15'h12, 16'h1234, 2'b11, 0, 1'b0);
        issue(RDOP, 15'h12, 16'h0000, 2'b01, 0, 1'b0);
        issue(WROP, 15'h12, 16'hAA55, 2'b10, 1, 1'b0);
        issue(RWOP, 15'h12, 16'h0F0F, 2'b01, 2, 1'b0);
        issue(RDOP, 15'h12, 16'h0000, 2'b11, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            issue((i % 2) ? WROP : RDOP, 15'(15'h20 + $urandom_range(0, 7)),
                  16'($urandom), 2'($urandom_range(1, 3)), 0, 1'b0);
        end

        // Reset during the second wait cycle of a read, then a late ack.
        exp_q.push_back(16'h0000);
        last_exp = '0;
        wait_cfg = 5;
        pi1_op = RDOP; pi1_addr = 15'h12; pi1_sel = 2'b11;
        @(posedge clk); #1;
        pi1_op = NOOP;
        check("abort_req_before", mem_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_req", mem_req, 0);
        check("abort_rdy", pi1_rdy, 1);
        check("abort_data", pi1_rdata, 0);
        ack_force = 1'b1;
        @(posedge clk); #1;
        ack_force = 1'b0;
        check("late_ack_req", mem_req, 0);
        check("late_ack_data", pi1_rdata, 0);
        @(posedge clk); #1;
        check("late_ack_rdy", pi1_rdy, 1);

`ifdef PI1_MEMBRIDGE_TIMEOUT_EN
        issue(RDOP, 15'h12, 16'h0000, 2'b11, 0, 1'b1);
        issue(RDOP, 15'h12, 16'h0000, 2'b11, TO_CYC, 1'b0);
        issue(RWOP, 15'h13, 16'h5A5A, 2'b11, 0, 1'b1);
        issue(RDOP, 15'h13, 16'h0000, 2'b11, 0, 1'b0);
`else
        issue(RDOP, 15'h12, 16'h0000, 2'b11, 3 * TO_CYC, 1'b0);
        issue(WROP, 15'h13, 16'h5A5A, 2'b11, 3 * TO_CYC, 1'b0);
`endif

        repeat (2) @(posedge clk);
        #3;
        check("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pi1_membridge.md
Name: pi1_membridge

Overview:
- Single-port PerInt slave that converts the one-at-a-time op stream from the PerInt queue's slave side into a req/ack word-memory transaction.
- Sits directly downstream of the queue's slave port and in front of SRAM/BRAM/external memory controllers with variable wait states.
- Serialises PIRWOP (atomic swap) into a read phase followed by a write phase.
- Each result is presented on pi1_data_o when pi1_rdy_o rises, so the queue can capture it on its next accept.

Parameters:
- ARCHBITSZ, 16, data width in bits (16/32/64); ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
- TIMEOUT, 255, max cycles mem_req_o may stay high without mem_ack_i; only used with the optional feature; must be >= 1.

Ports:
- clk_i  in  1  single clock for everything
- rst_i  in  1  synchronous, active-high reset
- pi1_op_i  in  2  PINOOP=00, PIWROP=01, PIRDOP=10, PIRWOP=11; sampled only when pi1_rdy_o=1
- pi1_addr_i  in  ADDRBITSZ  word address
- pi1_data_i  in  ARCHBITSZ  write data
- pi1_data_o  out  ARCHBITSZ  result of last completed read/swap
- pi1_sel_i  in  ARCHBITSZ/8  byte select
- pi1_rdy_o  out  1  1 = idle and accepting
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDRBITSZ  latched address
- mem_data_o  out  ARCHBITSZ  latched write data
- mem_sel_o  out  ARCHBITSZ/8  latched byte select
- mem_data_i  in  ARCHBITSZ  read data, valid in the cycle mem_ack_i=1
- mem_ack_i  in  1  one-cycle completion strobe; ignored when mem_req_o=0
- err_o  out  1  one-cycle timeout pulse (tied 0 without the feature)

Behaviour:
- States: IDLE, RD, WR, RWRD, RWWR. pi1_rdy_o = (state==IDLE), combinational from state only.
- Reset (any state): next state IDLE. pi1_data_o=0, mem_req_o=0, mem_we_o=0, err_o=0, timeout counter=0. mem_addr_o/data_o/sel_o are don't-care.
- Reset mid-transaction aborts it: mem_req_o is 0 the cycle after reset is sampled, and a late ack is ignored.
- IDLE, op=PINOOP: stay IDLE, no memory activity.
- IDLE, op!=PINOOP: latch addr/data/sel into the mem_* registers.
  - PIRDOP -> RD, mem_we_o=0.
  - PIWROP -> WR, mem_we_o=1.
  - PIRWOP -> RWRD, mem_we_o=0.
  - mem_req_o=1 from the next cycle.
- RD/RWRD with mem_ack_i=1: pi1_data_o <= mem_data_i (full word regardless of sel).
  - RD -> IDLE, mem_req_o=0.
  - RWRD -> RWWR, mem_req_o stays 1, mem_we_o=1, same latched addr/data/sel.
- WR/RWWR with mem_ack_i=1 -> IDLE, mem_req_o=0. pi1_data_o is unchanged, so a swap returns the old memory word.
- mem_req_o and all mem_* outputs are stable while waiting for ack.
- Latency with zero-wait memory (ack in the first req cycle):
  - RD/WR: accept at cycle N, req at N+1, pi1_rdy_o=1 at N+2.
  - RW: pi1_rdy_o=1 at N+3.
- Each extra wait cycle adds 1.
- Back-to-back: an op presented in the cycle pi1_rdy_o returns to 1 is accepted in that cycle. No bubble beyond the IDLE cycle.
- No ops are buffered. Inputs are ignored while pi1_rdy_o=0.

Optional Feature:
- Macro PI1_MEMBRIDGE_TIMEOUT_EN.
- Defined:
  - Counter (width clog2(TIMEOUT+1)) clears on each req phase start (including the RWRD->RWWR transition) and increments each cycle mem_req_o=1 && mem_ack_i=0.
  - If the counter equals TIMEOUT with no ack in that cycle:
    - mem_req_o=0 next cycle.
    - pi1_data_o <= all ones (for WR/RWWR too).
    - err_o=1 for exactly one cycle.
    - State -> IDLE; RWRD skips its write phase.
  - An ack in the same cycle the counter hits TIMEOUT wins; no error.
- Undefined: no counter; the bridge waits for ack indefinitely; err_o is constant 0.

Test Plan:
- Reset, then PIWROP addr=0x12 data=0xBEEF sel=11 with ack in the first req cycle -> mem_we_o=1, mem_addr_o=0x12, mem_data_o=0xBEEF for 1 cycle; pi1_rdy_o back to 1 two cycles after accept; pi1_data_o=0.
- PIRDOP addr=0x12, ack after 3 wait cycles with mem_data_i=0xBEEF -> mem_req_o high 4 cycles, pi1_data_o=0xBEEF when pi1_rdy_o rises.
- PIRWOP addr=0x12 data=0x1234, memory holding 0xBEEF, zero-wait -> read phase then write of 0x1234 without req dropping; pi1_data_o=0xBEEF; pi1_rdy_o=1 three cycles after accept.
- Continuous alternating RD/WR stream, zero-wait -> one accept every 2 cycles; all results match a reference memory model.
- rst_i asserted during the 2nd wait cycle of a read, then ack arrives -> mem_req_o=0 next cycle, pi1_data_o=0, pi1_rdy_o=1, late ack ignored.
- With PI1_MEMBRIDGE_TIMEOUT_EN, TIMEOUT=4, no ack on a read -> req high 5 cycles; err_o pulses once; pi1_data_o=0xFFFF; pi1_rdy_o=1 the next cycle. A separate case with ack on the 5th req cycle completes normally with err_o=0.
